// File: rtl/fetch_ctrl.sv
// Instruction fetch controller: one outstanding memory read at a time and one
// presented instruction. Redirects while a read is in flight discard its data.
module fetch_ctrl #(
    parameter int unsigned       ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_i,
    input  logic              branch_valid_i,
    input  logic [ADDR_W-1:0] branch_target_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_rdata_i,
    output logic              inst_valid_o,
    output logic [31:0]       inst_o,
    output logic [ADDR_W-1:0] inst_pc_o,
    output logic              chip_enable_o,
    output logic [ADDR_W-1:0] pc_o
);

    typedef enum logic [1:0] {IDLE, BUSY, VALID} state_t;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] hold_q, hold_d;
    logic [ADDR_W-1:0] inst_pc_q, inst_pc_d;
    logic [31:0]       inst_q, inst_d;
    logic              kill_q, kill_d;
    logic              valid_q, valid_d;
    logic              req;
    logic [ADDR_W-1:0] target;

    assign target = {branch_target_i[ADDR_W-1:2], 2'b00};

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= IDLE;
            pc_q      <= RESET_PC;
            kill_q    <= 1'b0;
            valid_q   <= 1'b0;
            inst_q    <= '0;
            inst_pc_q <= '0;
        end else begin
            state_q   <= state_d;
            pc_q      <= pc_d;
            kill_q    <= kill_d;
            valid_q   <= valid_d;
            inst_q    <= inst_d;
            inst_pc_q <= inst_pc_d;
        end
    end

    // Address of the read still in flight; only meaningful while kill_q is set.
    always_ff @(posedge clk) begin
        hold_q <= hold_d;
    end

    always_comb begin
        state_d   = state_q;
        pc_d      = pc_q;
        kill_d    = kill_q;
        hold_d    = hold_q;
        valid_d   = valid_q;
        inst_d    = inst_q;
        inst_pc_d = inst_pc_q;
        req       = 1'b0;
        unique case (state_q)
            IDLE: begin
                state_d = BUSY;
            end
            BUSY: begin
                req = 1'b1;
                if (imem_ack_i) begin
                    if (kill_q || branch_valid_i) begin
                        kill_d = 1'b0;
                        if (branch_valid_i) begin
                            pc_d = target;
                        end
                    end else begin
                        inst_d    = imem_rdata_i;
                        inst_pc_d = pc_q;
                        valid_d   = 1'b1;
                        pc_d      = pc_q + ADDR_W'(4);
                        state_d   = VALID;
                    end
                end else if (branch_valid_i) begin
                    // The first redirect latches the in-flight address; later ones only retarget.
                    if (!kill_q) begin
                        hold_d = pc_q;
                    end
                    kill_d = 1'b1;
                    pc_d   = target;
                end
            end
            VALID: begin
                if (branch_valid_i) begin
                    valid_d = 1'b0;
                    pc_d    = target;
                    state_d = BUSY;
                end else if (!stall_i) begin
                    valid_d = 1'b0;
                    state_d = BUSY;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign imem_req_o    = req;
    assign imem_addr_o   = kill_q ? hold_q : pc_q;
    assign chip_enable_o = (state_q != IDLE);
    assign pc_o          = pc_q;
    assign inst_valid_o  = valid_q;
    assign inst_o        = inst_q;
    assign inst_pc_o     = inst_pc_q;

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: vector table, directed multi-cycle sequences and a
// randomized run against a transaction-level reference model.
module tb_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        stall = 1'b0;
    logic        br = 1'b0;
    logic [31:0] tgt = '0;
    logic        ack = 1'b0;
    logic [31:0] rdata = '0;
    logic        req, valid, ce;
    logic [31:0] addr, inst, ipc, pc;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fetch_ctrl #(.ADDR_W(32), .RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst(rst), .stall_i(stall), .branch_valid_i(br),
        .branch_target_i(tgt), .imem_req_o(req), .imem_addr_o(addr),
        .imem_ack_i(ack), .imem_rdata_i(rdata), .inst_valid_o(valid),
        .inst_o(inst), .inst_pc_o(ipc), .chip_enable_o(ce), .pc_o(pc)
    );

    typedef struct {
        logic        s, b;
        logic [31:0] t;
        logic        a;
        logic [31:0] d;
        logic        e_ce, e_req;
        logic [31:0] e_addr, e_pc;
        logic        e_valid;
        logic [31:0] e_ipc, e_inst;
    } vec_t;

    vec_t tbl[16];

    function automatic vec_t mk(logic s, logic b, logic [31:0] t, logic a, logic [31:0] d,
                                logic e_ce, logic e_req, logic [31:0] e_addr, logic [31:0] e_pc,
                                logic e_valid, logic [31:0] e_ipc, logic [31:0] e_inst);
        vec_t v;
        v.s = s; v.b = b; v.t = t; v.a = a; v.d = d;
        v.e_ce = e_ce; v.e_req = e_req; v.e_addr = e_addr; v.e_pc = e_pc;
        v.e_valid = e_valid; v.e_ipc = e_ipc; v.e_inst = e_inst;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_all(input string nm, input logic e_ce, input logic e_req,
                           input logic [31:0] e_addr, input logic [31:0] e_pc, input logic e_valid,
                           input logic [31:0] e_ipc, input logic [31:0] e_inst);
        chk({nm, "_ce"}, 32'(ce), 32'(e_ce));
        chk({nm, "_req"}, 32'(req), 32'(e_req));
        chk({nm, "_addr"}, addr, e_addr);
        chk({nm, "_pc"}, pc, e_pc);
        chk({nm, "_valid"}, 32'(valid), 32'(e_valid));
        chk({nm, "_ipc"}, ipc, e_ipc);
        chk({nm, "_inst"}, inst, e_inst);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; stall = 1'b0; br = 1'b0; tgt = '0; ack = 1'b0; rdata = '0;
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic step(input logic s, input logic b, input logic [31:0] t,
                        input logic a, input logic [31:0] d);
        stall = s; br = b; tgt = t; ack = a; rdata = d;
        @(posedge clk);
        @(negedge clk);
        stall = 1'b0; br = 1'b0; ack = 1'b0;
    endtask

    // Reference model: a fetcher either presents an instruction or has one read in flight.
    bit          m_up, m_presenting, m_kill;
    logic [31:0] m_pc, m_inflight, m_inst, m_ipc;

    task automatic model_reset();
        m_up = 0; m_presenting = 0; m_kill = 0;
        m_pc = 32'h0; m_inflight = 32'h0; m_inst = 32'h0; m_ipc = 32'h0;
    endtask

    task automatic model_step(input logic s, input logic b, input logic [31:0] t,
                              input logic a, input logic [31:0] d);
        logic [31:0] aligned;
        aligned = t & 32'hFFFF_FFFC;
        if (!m_up) begin
            m_up = 1;
        end else if (m_presenting) begin
            if (b) begin
                m_presenting = 0;
                m_pc = aligned;
            end else if (!s) begin
                m_presenting = 0;
            end
        end else if (a) begin
            if (m_kill || b) begin
                m_kill = 0;
                if (b) m_pc = aligned;
            end else begin
                m_inst = d;
                m_ipc = m_pc;
                m_presenting = 1;
                m_pc = m_pc + 32'd4;
            end
        end else if (b) begin
            if (!m_kill) m_inflight = m_pc;
            m_kill = 1;
            m_pc = aligned;
        end
    endtask

    initial begin
        tbl[0]  = mk(0,0,0,1,32'h1111_0000, 0,0,32'h00,32'h00,0,32'h0,32'h0);
        tbl[1]  = mk(0,0,0,1,32'h1111_0000, 1,1,32'h00,32'h00,0,32'h0,32'h0);
        tbl[2]  = mk(0,0,0,1,32'h1111_0004, 1,0,32'h04,32'h04,1,32'h0,32'h1111_0000);
        tbl[3]  = mk(0,0,0,1,32'h1111_0004, 1,1,32'h04,32'h04,0,32'h0,32'h1111_0000);
        tbl[4]  = mk(0,0,0,1,32'h1111_0008, 1,0,32'h08,32'h08,1,32'h4,32'h1111_0004);
        tbl[5]  = mk(0,0,0,1,32'h1111_0008, 1,1,32'h08,32'h08,0,32'h4,32'h1111_0004);
        for (int i = 6; i <= 10; i++)
            tbl[i] = mk(1,0,0,1,32'h1111_000C, 1,0,32'h0C,32'h0C,1,32'h8,32'h1111_0008);
        tbl[11] = mk(0,0,0,1,32'h1111_000C, 1,0,32'h0C,32'h0C,1,32'h8,32'h1111_0008);
        tbl[12] = mk(0,0,0,1,32'h1111_000C, 1,1,32'h0C,32'h0C,0,32'h8,32'h1111_0008);
        tbl[13] = mk(1,1,32'h40,1,32'h1111_0040, 1,0,32'h10,32'h10,1,32'hC,32'h1111_000C);
        tbl[14] = mk(0,0,0,1,32'h1111_0040, 1,1,32'h40,32'h40,0,32'hC,32'h1111_000C);
        tbl[15] = mk(0,0,0,1,32'h1111_0044, 1,0,32'h44,32'h44,1,32'h40,32'h1111_0040);

        // Reset values asserted while rst is low.
        #1;
        chk_all("reset", 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);

        do_reset();
        for (int i = 0; i < 16; i++) begin
            chk_all($sformatf("row%0d", i), tbl[i].e_ce, tbl[i].e_req, tbl[i].e_addr,
                    tbl[i].e_pc, tbl[i].e_valid, tbl[i].e_ipc, tbl[i].e_inst);
            step(tbl[i].s, tbl[i].b, tbl[i].t, tbl[i].a, tbl[i].d);
        end

        // Redirect together with ack, then a 3-cycle-late ack at 0x10.
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 1, 32'h10, 1, 32'hBAD0_0000);
        chk("same_cycle_br_valid", 32'(valid), 0);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("wait%0d_req", i), 32'(req), 1);
            chk($sformatf("wait%0d_addr", i), addr, 32'h10);
            chk($sformatf("wait%0d_valid", i), 32'(valid), 0);
            step(0, 0, 0, (i == 3), 32'hCAFE_0010);
        end
        chk_all("late_ack", 1, 0, 32'h14, 32'h14, 1, 32'h10, 32'hCAFE_0010);
        step(0, 0, 0, 0, 0);
        chk("pulse_once_valid", 32'(valid), 0);
        chk("pulse_once_addr", addr, 32'h14);

        // Redirect to 0x103 while the read of 0x8 is in flight.
        do_reset();
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h0);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 1, 32'h4);
        step(0, 0, 0, 0, 0);
        chk("pre_kill_addr", addr, 32'h8);
        step(0, 1, 32'h103, 0, 0);
        chk_all("kill0", 1, 1, 32'h8, 32'h100, 0, 32'h4, 32'h4);
        step(0, 0, 0, 0, 0);
        chk_all("kill1", 1, 1, 32'h8, 32'h100, 0, 32'h4, 32'h4);
        step(0, 0, 0, 1, 32'hDEAD_0008);
        chk_all("kill_ack", 1, 1, 32'h100, 32'h100, 0, 32'h4, 32'h4);
        // Two redirects while the 0x100 read is pending: a single discard.
        step(0, 1, 32'h200, 0, 0);
        chk("k2_addr", addr, 32'h100);
        chk("k2_pc", pc, 32'h200);
        step(0, 1, 32'h305, 0, 0);
        chk("k3_addr", addr, 32'h100);
        chk("k3_pc", pc, 32'h304);
        step(0, 0, 0, 1, 32'h0BAD_0BAD);
        chk_all("k3_ack", 1, 1, 32'h304, 32'h304, 0, 32'h4, 32'h4);
        step(0, 0, 0, 1, 32'h77);
        chk_all("k3_fetch", 1, 0, 32'h308, 32'h308, 1, 32'h304, 32'h77);

        // PC wraparound at the top of the address space.
        step(0, 1, 32'hFFFF_FFFC, 0, 0);
        chk("wrap_addr", addr, 32'hFFFF_FFFC);
        step(0, 0, 0, 1, 32'h1234_5678);
        chk_all("wrap_fetch", 1, 0, 32'h0, 32'h0, 1, 32'hFFFF_FFFC, 32'h1234_5678);
        step(0, 0, 0, 0, 0);
        chk("wrap_next_req", 32'(req), 1);
        chk("wrap_next_addr", addr, 32'h0);

        // Reset pulse mid-request, with a late ack after release.
        step(0, 0, 0, 0, 0);
        ack = 1'b1; rdata = 32'h5555_5555;
        rst = 1'b0;
        #1;
        chk_all("rst_busy", 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        @(negedge clk);
        rst = 1'b1;
        chk_all("rst_release", 0, 0, 32'h0, 32'h0, 0, 32'h0, 32'h0);
        step(0, 0, 0, 1, 32'h5555_5555);
        chk_all("late_ack_ignored", 1, 1, 32'h0, 32'h0, 0, 32'h0, 32'h0);

        // Randomized run against the reference model.
        do_reset();
        model_reset();
        for (int c = 0; c < 3000; c++) begin
            logic        rs, rb, ra;
            logic [31:0] rt, rd;
            chk("rnd_ce", 32'(ce), 32'(m_up));
            chk("rnd_req", 32'(req), 32'(m_up && !m_presenting));
            chk("rnd_addr", addr, m_kill ? m_inflight : m_pc);
            chk("rnd_pc", pc, m_pc);
            chk("rnd_valid", 32'(valid), 32'(m_presenting));
            if (m_presenting) begin
                chk("rnd_ipc", ipc, m_ipc);
                chk("rnd_inst", inst, m_inst);
            end
            rs = ($urandom_range(0, 2) == 0);
            rb = ($urandom_range(0, 6) == 0);
            rt = $urandom;
            if ($urandom_range(0, 3) == 0) rt = 32'hFFFF_FFF0 | (rt & 32'hF);
            ra = req && ($urandom_range(0, 1) == 1);
            rd = $urandom;
            step(rs, rb, rt, ra, rd);
            model_step(rs, rb, rt, ra, rd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
